// File: rtl/bidir_port_ctrl.sv
// Bidirectional pad controller: tristate write bursts with hi-Z turnaround,
// single-shot pad reads in IDLE, and a sticky read-back contention flag.
module bidir_port_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] io,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             oe,
  output logic             contention,
  input  logic             contention_clr
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TA_OUT = 2'd1;
  localparam logic [1:0] S_DRIVE  = 2'd2;
  localparam logic [1:0] S_TA_IN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             cont_q, cont_d;
  logic             oe_q, oe_d;
  logic             wr_ready_q, wr_ready_d;
  logic             rd_ready_q, rd_ready_d;
  logic             match_c;

  assign io         = oe_q ? dout_q : {WIDTH{1'bz}};
  assign oe         = oe_q;
  assign wr_ready   = wr_ready_q;
  assign rd_ready   = rd_ready_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign contention = cont_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    cont_d     = cont_q;
    // An X/Z bit makes the equality unknown, which falls through as a mismatch
    match_c    = 1'b0;
    if (io == dout_q) match_c = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          rd_data_d  = io;
          rd_valid_d = 1'b1;
        end
        if (wr_valid) begin
          dout_d  = wr_data;
          cnt_d   = TURN_LD;
          state_d = S_TA_OUT;
        end
      end
      S_TA_OUT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (wr_valid) begin
          dout_d = wr_data;
        end else begin
          cnt_d   = TURN_LD;
          state_d = S_TA_IN;
        end
      end
      S_TA_IN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Set beats clear when both happen on the same edge
    if (contention_clr) cont_d = 1'b0;
    if ((state_q == S_DRIVE) && !match_c) cont_d = 1'b1;

    oe_d       = (state_d == S_DRIVE);
    wr_ready_d = (state_d == S_IDLE) || (state_d == S_DRIVE);
    rd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dout_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cont_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_ready_q <= 1'b1;
      rd_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cont_q     <= cont_d;
      oe_q       <= oe_d;
      wr_ready_q <= wr_ready_d;
      rd_ready_q <= rd_ready_d;
    end
  end

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Scoreboard bench for bidir_port_ctrl: directed scenarios plus random traffic
// against a turnaround-timeline reference model.
module tb_bidir_port_ctrl;
  localparam int unsigned W = 8;
  localparam int unsigned T = 2;

  logic         clk = 1'b0;
  logic         rst;
  wire  [W-1:0] io;
  logic         wr_valid, rd_req, contention_clr;
  logic [W-1:0] wr_data;
  logic         wr_ready, rd_ready, rd_valid, oe, contention;
  logic [W-1:0] rd_data;
  logic         ext_en;
  logic [W-1:0] ext_data;

  assign io = ext_en ? ext_data : {W{1'bz}};

  bidir_port_ctrl #(.WIDTH(W), .TURN_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .io(io),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .oe(oe), .contention(contention), .contention_clr(contention_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_rd_q[$];
  logic [W-1:0] exp_drv_q[$];
  bit force_ext = 1'b0;

  // Reference model: remaining hi-Z cycles before/after a drive window
  int           m_out_left = 0;
  int           m_in_left  = 0;
  bit           m_drv  = 1'b0;
  bit           m_rdv  = 1'b0;
  bit           m_cont = 1'b0;
  logic [W-1:0] m_word = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out_left = 0; m_in_left = 0;
    m_drv = 1'b0; m_rdv = 1'b0; m_cont = 1'b0; m_word = '0;
    exp_rd_q.delete();
    exp_drv_q.delete();
  endtask

  // Apply one cycle of stimulus, advance the model, check control outputs
  task automatic cycle(input bit wv, input logic [W-1:0] wd, input bit rr,
                       input bit clr, input logic [W-1:0] ed);
    bit idle, acc, idle_n;
    idle = !m_drv && (m_out_left == 0) && (m_in_left == 0);
    wr_valid = wv; wr_data = wd; rd_req = rr; contention_clr = clr;
    ext_data = ed;
    ext_en   = force_ext || !m_drv;
    acc = wv && (idle || m_drv);
    m_rdv = idle && rr;
    if (m_rdv) exp_rd_q.push_back(ed);
    if (clr) m_cont = 1'b0;
    if (m_drv && force_ext && (ed != m_word)) m_cont = 1'b1;
    if (acc) begin
      exp_drv_q.push_back(wd);
      m_word = wd;
    end
    if (idle) begin
      if (wv) m_out_left = T;
    end else if (m_out_left > 0) begin
      m_out_left--;
      if (m_out_left == 0) m_drv = 1'b1;
    end else if (m_drv) begin
      if (!wv) begin
        m_drv = 1'b0;
        m_in_left = T;
      end
    end else begin
      m_in_left--;
    end
    @(posedge clk);
    @(negedge clk);
    idle_n = !m_drv && (m_out_left == 0) && (m_in_left == 0);
    chk("oe", 64'(oe), 64'(m_drv));
    chk("wr_ready", 64'(wr_ready), 64'(idle_n || m_drv));
    chk("rd_ready", 64'(rd_ready), 64'(idle_n));
    chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
    chk("contention", 64'(contention), 64'(m_cont));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, W'($urandom));
  endtask

  // Monitor: pops expected read data and driven words as the DUT presents them
  initial begin
    logic [W-1:0] w;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (rd_valid) begin
          if (exp_rd_q.size() == 0) chk("rd_valid_unexpected", 64'(rd_valid), 64'd0);
          else chk("rd_data", 64'(rd_data), 64'(exp_rd_q.pop_front()));
        end
        if (oe) begin
          if (exp_drv_q.size() == 0) chk("drive_unexpected", 64'(oe), 64'd0);
          else begin
            w = exp_drv_q.pop_front();
            if (!force_ext) chk("io_drive", 64'(io), 64'(w));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ext_en = 1'b0; ext_data = '0;
    wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0; contention_clr = 1'b0;
    #2 rst = 1'b1;
    #2;
    chk("reset_oe", 64'(oe), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_contention", 64'(contention), 64'd0);
    chk("reset_rd_ready", 64'(rd_ready), 64'd1);
    chk("reset_wr_ready", 64'(wr_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    // write burst
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    idle_cycles(T + 2);

    // read
    cycle(1'b0, '0, 1'b1, 1'b0, 8'hA5);
    cycle(1'b0, '0, 1'b0, 1'b0, 8'hA5);
    idle_cycles(1);

    // simultaneous write and read
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 8'h5A);
    idle_cycles(T + T + 3);

    // ignored requests during TA_IN
    cycle(1'b1, 8'h44, 1'b0, 1'b0, 8'h00);
    idle_cycles(T + 1);
    for (int i = 0; i < T; i++) cycle(1'b1, 8'h99, 1'b1, 1'b0, 8'h66);
    idle_cycles(2);

    // contention, then hold, then clear
    force_ext = 1'b1;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, 8'hC3);
    for (int i = 0; i < T + 1; i++) cycle(1'b0, '0, 1'b0, 1'b0, 8'hC3);
    force_ext = 1'b0;
    idle_cycles(T + 1);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h00);
    idle_cycles(1);

    // set and clear on the same edge: set wins; left set going into reset
    force_ext = 1'b1;
    cycle(1'b1, 8'h3C, 1'b0, 1'b1, 8'hC3);
    for (int i = 0; i < T; i++) cycle(1'b0, '0, 1'b0, 1'b1, 8'hC3);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'hC3);
    force_ext = 1'b0;
    idle_cycles(T + 1);

    // async reset mid-DRIVE
    cycle(1'b1, 8'h5F, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < T + 1; i++) cycle(1'b1, 8'h6E, 1'b0, 1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("arst_oe", 64'(oe), 64'd0);
    chk("arst_rd_valid", 64'(rd_valid), 64'd0);
    chk("arst_rd_data", 64'(rd_data), 64'd0);
    chk("arst_contention", 64'(contention), 64'd0);
    chk("arst_rd_ready", 64'(rd_ready), 64'd1);
    chk("arst_wr_ready", 64'(wr_ready), 64'd1);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    idle_cycles(1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), W'($urandom));
    end
    idle_cycles(2 * T + 4);
    chk("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
    chk("drv_queue_empty", 64'(exp_drv_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
